// File: rtl/uart_frame_rx_pkg.sv
// Shared types and constants for the UART frame deframer.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CSUM,
    DRAIN
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_rx_if.sv
// Byte-in / stream-out bundle of the deframer. The slave modport is the
// deframer's view; the master modport is the surrounding logic's view.
interface uart_frame_rx_if #(
  parameter int dbit = 8
);
  logic            rx_done_tick;
  logic [dbit-1:0] din;
  logic            m_valid;
  logic [dbit-1:0] m_data;
  logic            m_last;
  logic            m_ready;
  logic            frame_err;
  logic [1:0]      err_code;
  logic            overrun;

  modport slave (
    input  rx_done_tick, din, m_ready,
    output m_valid, m_data, m_last, frame_err, err_code, overrun
  );

  modport master (
    output rx_done_tick, din, m_ready,
    input  m_valid, m_data, m_last, frame_err, err_code, overrun
  );
endinterface

// File: rtl/uart_frame_rx_frame_buf.sv
// Payload buffer: depth x dbit register file, one synchronous write port
// and one asynchronous read port. Contents need no reset.
module frame_buf #(
  parameter int dbit  = 8,
  parameter int depth = 16,
  parameter int aw    = 4
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [aw-1:0]   waddr_i,
  input  logic [dbit-1:0] wdata_i,
  input  logic [aw-1:0]   raddr_i,
  output logic [dbit-1:0] rdata_o
);

  logic [dbit-1:0] mem_q [depth];

  // Store one payload byte per write strobe.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_frame_rx.sv
// UART byte-stream deframer: SOF, LEN, LEN payload bytes, CSUM.
// CSUM is the mod-2^dbit sum of LEN and all payload bytes. Payload is
// buffered and released as a valid/ready stream only after CSUM matches.
// Optional inter-byte timeout: define UART_FRAME_RX_TIMEOUT_EN.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int              dbit           = 8,
  parameter int              max_len        = 16,
  parameter logic [dbit-1:0] sof            = dbit'(SOF_DEFAULT),
  parameter int              timeout_cycles = 100000
) (
  input logic          clk,
  input logic          reset,
  uart_frame_rx_if.slave bus
);

  localparam int              AW        = (max_len > 1) ? $clog2(max_len) : 1;
  localparam logic [dbit-1:0] MAX_LEN_W = dbit'(max_len);

  state_e          state_q;
  logic [dbit-1:0] len_q, wr_idx_q, rd_idx_q, sum_q;
  logic            m_valid_q, m_last_q, frame_err_q, overrun_q;
  logic [dbit-1:0] m_data_q;
  logic [1:0]      err_code_q;

  logic            tick;
  logic [dbit-1:0] din;
  logic            hs;
  logic [dbit-1:0] rd_next, sum_d;
  logic            buf_we;
  logic [AW-1:0]   buf_raddr;
  logic [dbit-1:0] buf_rdata;
  logic            tmo_hit;

  assign tick    = bus.rx_done_tick;
  assign din     = bus.din;
  assign hs      = m_valid_q && bus.m_ready;
  assign rd_next = rd_idx_q + 1'b1;
  assign sum_d   = sum_q + din;
  assign buf_we  = tick && (state_q == PAYLOAD);
  // While draining, look one entry ahead so the next byte is ready at the
  // handshake; on CSUM acceptance the first entry is loaded.
  assign buf_raddr = (state_q == DRAIN) ? rd_next[AW-1:0] : '0;

  frame_buf #(
    .dbit (dbit),
    .depth(max_len),
    .aw   (AW)
  ) u_buf (
    .clk    (clk),
    .we_i   (buf_we),
    .waddr_i(wr_idx_q[AW-1:0]),
    .wdata_i(din),
    .raddr_i(buf_raddr),
    .rdata_o(buf_rdata)
  );

`ifdef UART_FRAME_RX_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles) + 1;

  logic [TW-1:0] tmo_q;
  logic          in_frame;

  assign in_frame = (state_q == LEN) || (state_q == PAYLOAD) || (state_q == CSUM);
  // A byte arriving on the expiry cycle takes priority over the timeout.
  assign tmo_hit  = in_frame && !tick && (tmo_q == TW'(timeout_cycles - 1));

  // Idle-gap counter: runs only inside a frame, cleared by every byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_q <= '0;
    end else if (in_frame && !tick && !tmo_hit) begin
      tmo_q <= tmo_q + 1'b1;
    end else begin
      tmo_q <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Frame parser FSM with registered stream and error outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      sum_q       <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      overrun_q   <= 1'b0;
      if (tmo_hit) begin
        state_q     <= IDLE;
        frame_err_q <= 1'b1;
        err_code_q  <= ERR_TIMEOUT;
      end else begin
        case (state_q)
          IDLE: begin
            if (tick && din == sof) state_q <= LEN;
          end
          LEN: begin
            if (tick) begin
              if (din == '0 || din > MAX_LEN_W) begin
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_LEN;
              end else begin
                len_q    <= din;
                wr_idx_q <= '0;
                sum_q    <= din;
                state_q  <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            if (tick) begin
              sum_q    <= sum_d;
              wr_idx_q <= wr_idx_q + 1'b1;
              if (wr_idx_q == len_q - 1'b1) state_q <= CSUM;
            end
          end
          CSUM: begin
            if (tick) begin
              if (din == sum_q) begin
                rd_idx_q  <= '0;
                m_valid_q <= 1'b1;
                m_data_q  <= buf_rdata;
                m_last_q  <= (len_q == dbit'(1));
                state_q   <= DRAIN;
              end else begin
                state_q     <= IDLE;
                frame_err_q <= 1'b1;
                err_code_q  <= ERR_CSUM;
              end
            end
          end
          DRAIN: begin
            // Input bytes cannot be accepted while draining; flag and drop.
            if (tick) overrun_q <= 1'b1;
            if (hs) begin
              if (m_last_q) begin
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
                m_data_q  <= '0;
                state_q   <= IDLE;
              end else begin
                rd_idx_q <= rd_next;
                m_data_q <= buf_rdata;
                m_last_q <= (rd_next == len_q - 1'b1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_last    = m_last_q;
  assign bus.frame_err = frame_err_q;
  assign bus.err_code  = err_code_q;
  assign bus.overrun   = overrun_q;

endmodule
